serial_cmd_ctrl: RTL
====================

# serial_cmd_ctrl

Serial command controller between the UART receiver/transmitter pair and the RGB status LED driver. It assembles two-byte command frames (address, command) from received bytes and validates them. It issues a one-cycle command strobe and returns a one-byte acknowledge through the transmitter. It generates the WAIT, error and reset-indication flags that the LED driver consumes.

## Interface
- TIMEOUT_CYC, 5_000_000: cycles allowed between address byte and command byte (100 ms at 50 MHz).
- CMD_MAX, 8'h0F: highest valid command code; codes above are rejected.
- clk  in  1  system clock, all logic on rising edge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- rx_data  in  8  received byte, valid only with rx_valid.
- rx_valid  in  1  one-cycle strobe, new byte on rx_data.
- rx_err  in  1  one-cycle strobe, framing/stop-bit error from receiver.
- tx_busy  in  1  transmitter busy; tx_start ignored while high.
- tx_data  out  8  byte to transmit, stable while tx_start high.
- tx_start  out  1  one-cycle request to transmitter.
- cmd_addr  out  5  address of last accepted frame.
- cmd_code  out  8  command of last accepted frame.
- cmd_valid  out  1  one-cycle strobe, cmd_addr/cmd_code updated.
- WAIT  out  1  frame in progress (to LED green).
- error  out  1  last frame rejected (to LED red).
- rst_ind  out  1  no frame accepted since reset (to LED blue).

## Operation
- States: IDLE, GET_CMD, SEND, ERR.
- Reset values: state IDLE, tx_data 8'h00, tx_start 0, cmd_addr 0, cmd_code 0, cmd_valid 0, WAIT 0, error 0, rst_ind 1, timeout counter 0.
- IDLE: on rx_valid, address byte checked; rx_data[7:5]==0 -> latch addr, go GET_CMD; else tx_data=8'hEE, go ERR.
- GET_CMD: counter increments each cycle. On rx_valid with rx_data<=CMD_MAX -> cmd_addr/cmd_code updated, cmd_valid pulse, tx_data={4'hA,rx_data[3:0]}, rst_ind cleared, go SEND. On rx_valid with rx_data>CMD_MAX -> tx_data=8'hEE, go ERR. Counter reaching TIMEOUT_CYC-1 without rx_valid -> tx_data=8'hEE, go ERR.
- SEND: tx_start pulsed in first cycle with tx_busy=0, then go IDLE.
- ERR: error=1; nack (8'hEE) sent with same tx_busy rule as SEND, once per entry. Afterwards remains in ERR with error=1. Next rx_valid (after nack issued) clears error and is processed exactly as an address byte in IDLE.
- rx_err in any state: tx_data=8'hEE, go ERR (re-entry re-arms nack); rx_err has priority over rx_valid in the same cycle.
- rx_valid in SEND, or in ERR before nack issued: byte discarded.
- WAIT=1 in GET_CMD and SEND, 0 otherwise. error=1 only in ERR. rst_ind set only by reset.
- Counter cleared on every entry to GET_CMD; width $clog2(TIMEOUT_CYC).

## Timing
- All outputs registered.
- Command byte rx_valid at cycle n -> cmd_valid, WAIT still 1, state SEND at n+1; tx_start earliest n+1 (if tx_busy low), state IDLE and WAIT=0 at following cycle.
- Address byte rx_valid at n -> WAIT=1 at n+1.
- Timeout: last counter cycle at n -> error=1 at n+1, tx_start earliest n+1.
- tx_busy high holds SEND/ERR indefinitely; tx_data constant meanwhile.
- reset mid-frame or mid-send: outputs return to reset values asynchronously; pending ack/nack dropped.

## Configuration
- SERIAL_CMD_TIMEOUT_EN defined: timeout counter and GET_CMD->ERR timeout transition present.
- Not defined: no counter; GET_CMD waits indefinitely for command byte; TIMEOUT_CYC unused.

## Test plan
- After reset: rst_ind=1, WAIT=0, error=0; bytes 8'h05, 8'h03 -> cmd_valid pulse with cmd_addr=5, cmd_code=3, tx_data=8'hA3 with one tx_start, rst_ind=0.
- Address 8'h25 -> error=1, tx_data=8'hEE one tx_start; next bytes 8'h01,8'h02 -> error=0, ack 8'hA2.
- Address 8'h01 then command 8'h10 -> no cmd_valid, nack 8'hEE, error=1.
- Macro defined, TIMEOUT_CYC=16: address 8'h01, no further byte -> error=1 exactly 16 cycles after WAIT rises, nack sent; macro undefined -> WAIT stays 1 for 1000 cycles.
- tx_busy held high 20 cycles during SEND -> tx_start delayed to first cycle tx_busy=0, rx_valid during hold discarded.
- rx_err asserted same cycle as command byte in GET_CMD -> ERR, nack, no cmd_valid; reset asserted mid-SEND -> no tx_start, rst_ind=1.

Source files
------------

// File: rtl/serial_cmd_ctrl.sv
// rtl/serial_cmd_ctrl.sv - two-byte UART command framer with ack/nack and LED status flags
// Optional GET_CMD timeout is built when SERIAL_CMD_TIMEOUT_EN is defined.
module serial_cmd_ctrl #(
    parameter int unsigned TIMEOUT_CYC = 5_000_000,
    parameter logic [7:0]  CMD_MAX     = 8'h0F
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    input  logic       rx_err,
    input  logic       tx_busy,
    output logic [7:0] tx_data,
    output logic       tx_start,
    output logic [4:0] cmd_addr,
    output logic [7:0] cmd_code,
    output logic       cmd_valid,
    output logic       WAIT,
    output logic       error,
    output logic       rst_ind
);

    typedef enum logic [1:0] {IDLE, GET_CMD, SEND, ERR} state_t;

    localparam logic [7:0] NACK = 8'hEE;

    state_t     state, state_nxt;
    logic       pending, pending_nxt;
    logic [4:0] addr_q, addr_nxt;
    logic [7:0] tx_data_nxt;
    logic       tx_start_nxt;
    logic [4:0] cmd_addr_nxt;
    logic [7:0] cmd_code_nxt;
    logic       cmd_valid_nxt;
    logic       rst_ind_nxt;
    logic       byte_in;
    logic       addr_byte;
    logic       go_err;
    logic       go_send;
    logic       timed_out;

    // rx_err wins over a byte arriving in the same cycle
    assign byte_in = rx_valid && !rx_err;

`ifdef SERIAL_CMD_TIMEOUT_EN
    localparam int CW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYC - 1);

    logic [CW-1:0] cnt;

    // Only GET_CMD advances the counter, so every entry starts from zero
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (state_nxt == GET_CMD && state == GET_CMD) begin
            cnt <= cnt + CW'(1);
        end else begin
            cnt <= '0;
        end
    end

    assign timed_out = (state == GET_CMD) && (cnt == CNT_LAST);
`else
    assign timed_out = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            pending   <= 1'b0;
            addr_q    <= '0;
            tx_data   <= 8'h00;
            tx_start  <= 1'b0;
            cmd_addr  <= '0;
            cmd_code  <= '0;
            cmd_valid <= 1'b0;
            WAIT      <= 1'b0;
            error     <= 1'b0;
            rst_ind   <= 1'b1;
        end else begin
            state     <= state_nxt;
            pending   <= pending_nxt;
            addr_q    <= addr_nxt;
            tx_data   <= tx_data_nxt;
            tx_start  <= tx_start_nxt;
            cmd_addr  <= cmd_addr_nxt;
            cmd_code  <= cmd_code_nxt;
            cmd_valid <= cmd_valid_nxt;
            WAIT      <= (state_nxt == GET_CMD) || (state_nxt == SEND);
            error     <= (state_nxt == ERR);
            rst_ind   <= rst_ind_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        pending_nxt   = pending;
        addr_nxt      = addr_q;
        tx_data_nxt   = tx_data;
        tx_start_nxt  = 1'b0;
        cmd_addr_nxt  = cmd_addr;
        cmd_code_nxt  = cmd_code;
        cmd_valid_nxt = 1'b0;
        rst_ind_nxt   = rst_ind;
        addr_byte     = 1'b0;
        go_err        = 1'b0;
        go_send       = 1'b0;

        case (state)
            IDLE: begin
                addr_byte = byte_in;
            end
            GET_CMD: begin
                if (byte_in) begin
                    if (rx_data <= CMD_MAX) begin
                        go_send = 1'b1;
                    end else begin
                        go_err = 1'b1;
                    end
                end else if (timed_out) begin
                    go_err = 1'b1;
                end
            end
            SEND: begin
                if (!pending) begin
                    state_nxt = IDLE;
                end else if (!tx_busy) begin
                    tx_start_nxt = 1'b1;
                    pending_nxt  = 1'b0;
                end
            end
            ERR: begin
                // Bytes are ignored until this entry's nack has gone out
                if (pending) begin
                    if (!tx_busy) begin
                        tx_start_nxt = 1'b1;
                        pending_nxt  = 1'b0;
                    end
                end else begin
                    addr_byte = byte_in;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        if (addr_byte) begin
            if (rx_data[7:5] == 3'b000) begin
                addr_nxt  = rx_data[4:0];
                state_nxt = GET_CMD;
            end else begin
                go_err = 1'b1;
            end
        end

        // The response byte is requested on entry when the transmitter is free,
        // otherwise pending holds it until tx_busy drops.
        if (go_send) begin
            cmd_addr_nxt  = addr_q;
            cmd_code_nxt  = rx_data;
            cmd_valid_nxt = 1'b1;
            tx_data_nxt   = {4'hA, rx_data[3:0]};
            rst_ind_nxt   = 1'b0;
            state_nxt     = SEND;
            tx_start_nxt  = !tx_busy;
            pending_nxt   = tx_busy;
        end

        if (go_err || rx_err) begin
            state_nxt    = ERR;
            tx_data_nxt  = NACK;
            tx_start_nxt = !tx_busy;
            pending_nxt  = tx_busy;
        end
    end

endmodule
